pc_sequencer: RTL

Instruction sequencer for the Salamander-4 core. It drives the program counter's `inc` / `cnt_overwrite` / `cnt_new_val` controls and runs fetch–decode–execute. Handshakes:

- instruction memory: `imem_req` / `imem_ack`
- ALU/execute stage: `ex_start` / `ex_done`

It resolves jumps, conditional branches, halts and (optionally) call/return, and reports PC wrap and illegal targets as faults.

---
 rtl/pc_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Salamander-4 instruction sequencer: fetch/decode/execute control plus PC counter strobes.
// Optional return stack for CALL/RET is compiled in with `define PC_CALL_STACK_EN.
module pc_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int OPC_W       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       pc_val,
  input  logic                    pc_max,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic [ADDR_W-1:0]       pc_load_val,
  output logic                    imem_req,
  input  logic                    imem_ack,
  input  logic [OPC_W+ADDR_W-1:0] imem_data,
  output logic [OPC_W+ADDR_W-1:0] ir,
  output logic                    ex_start,
  input  logic                    ex_done,
  input  logic                    flag_z,
  output logic                    busy,
  output logic                    halted,
  output logic                    fault
);

  localparam int IW = OPC_W + ADDR_W;
  localparam logic [OPC_W-1:0]  OP_HLT   = '1;
  localparam logic [OPC_W-1:0]  OP_JMP   = OP_HLT - OPC_W'(1);
  localparam logic [OPC_W-1:0]  OP_JZ    = OP_HLT - OPC_W'(2);
  localparam logic [OPC_W-1:0]  OP_CALL  = OP_HLT - OPC_W'(3);
  localparam logic [OPC_W-1:0]  OP_RET   = OP_HLT - OPC_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_BAD = '1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t            r_state, w_state_nxt;
  state_t            r_dec_next, w_dec_nxt;
  logic [IW-1:0]     r_ir, w_ir_nxt;
  logic              r_pc_inc, w_pc_inc_nxt;
  logic              r_pc_load, w_pc_load_nxt;
  logic [ADDR_W-1:0] r_pc_load_val, w_pc_load_val_nxt;
  logic              r_req, w_req_nxt;
  logic              r_ex_start, w_ex_start_nxt;
  logic              r_fault, w_fault_set;
  logic              w_jump;
  logic [ADDR_W-1:0] w_tgt;
  logic [OPC_W-1:0]  w_opc;
  logic [ADDR_W-1:0] w_opnd;

  assign w_opc  = imem_data[IW-1:ADDR_W];
  assign w_opnd = imem_data[ADDR_W-1:0];

`ifdef PC_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]   r_sp;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic              w_push, w_pop, w_full, w_empty;
  logic [ADDR_W-1:0] w_top, w_ret_addr;

  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_top      = r_stack[IDX_W'(r_sp - SP_W'(1))];
  assign w_ret_addr = pc_val + ADDR_W'(1);
`else
  logic w_unused_pc;
  assign w_unused_pc = ^{pc_val, STACK_DEPTH[0]};
`endif

  // The instruction is decoded as it is accepted, so the DECODE-cycle strobes come straight from flops.
  always_comb begin
    w_state_nxt       = r_state;
    w_dec_nxt         = r_dec_next;
    w_ir_nxt          = r_ir;
    w_pc_inc_nxt      = 1'b0;
    w_pc_load_nxt     = 1'b0;
    w_pc_load_val_nxt = r_pc_load_val;
    w_req_nxt         = 1'b0;
    w_ex_start_nxt    = 1'b0;
    w_fault_set       = 1'b0;
    w_jump            = 1'b0;
    w_tgt             = w_opnd;
`ifdef PC_CALL_STACK_EN
    w_push            = 1'b0;
    w_pop             = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_req_nxt   = 1'b1;
        end
      end
      S_FETCH: begin
        if (pc_max) begin
          w_fault_set = 1'b1;
          w_state_nxt = S_HALT;
        end else if (imem_ack) begin
          w_state_nxt = S_DECODE;
          w_ir_nxt    = imem_data;
          case (w_opc)
            OP_HLT: w_dec_nxt = S_HALT;
            OP_JMP: w_jump = 1'b1;
            OP_JZ: begin
              if (flag_z) begin
                w_jump = 1'b1;
              end else begin
                w_pc_inc_nxt = 1'b1;
                w_dec_nxt    = S_FETCH;
              end
            end
            OP_CALL: begin
`ifdef PC_CALL_STACK_EN
              if (w_full || pc_val == ADDR_BAD) begin
                w_fault_set = 1'b1;
                w_dec_nxt   = S_HALT;
              end else begin
                w_push = (w_opnd != ADDR_BAD);
                w_jump = 1'b1;
              end
`else
              w_fault_set = 1'b1;
              w_dec_nxt   = S_HALT;
`endif
            end
            OP_RET: begin
`ifdef PC_CALL_STACK_EN
              if (w_empty) begin
                w_fault_set = 1'b1;
                w_dec_nxt   = S_HALT;
              end else begin
                w_pop  = 1'b1;
                w_tgt  = w_top;
                w_jump = 1'b1;
              end
`else
              w_fault_set = 1'b1;
              w_dec_nxt   = S_HALT;
`endif
            end
            default: begin
              w_ex_start_nxt = 1'b1;
              w_dec_nxt      = S_EXEC;
            end
          endcase
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_DECODE: begin
        w_state_nxt = r_dec_next;
        w_req_nxt   = (r_dec_next == S_FETCH);
      end
      S_EXEC: begin
        // ex_done arms pc_inc; the strobe cycle itself is the hand-off back to FETCH.
        if (r_pc_inc) begin
          w_state_nxt = S_FETCH;
          w_req_nxt   = 1'b1;
        end else if (ex_done) begin
          w_pc_inc_nxt = 1'b1;
        end
      end
      default: ;
    endcase
    // The counter refuses the all-ones address, so never present it as a load.
    if (w_jump) begin
      if (w_tgt == ADDR_BAD) begin
        w_fault_set = 1'b1;
        w_dec_nxt   = S_HALT;
      end else begin
        w_pc_load_nxt     = 1'b1;
        w_pc_load_val_nxt = w_tgt;
        w_dec_nxt         = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_dec_next    <= S_IDLE;
      r_ir          <= '0;
      r_pc_inc      <= 1'b0;
      r_pc_load     <= 1'b0;
      r_pc_load_val <= '0;
      r_req         <= 1'b0;
      r_ex_start    <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_dec_next    <= w_dec_nxt;
      r_ir          <= w_ir_nxt;
      r_pc_inc      <= w_pc_inc_nxt;
      r_pc_load     <= w_pc_load_nxt;
      r_pc_load_val <= w_pc_load_val_nxt;
      r_req         <= w_req_nxt;
      r_ex_start    <= w_ex_start_nxt;
      r_fault       <= r_fault | w_fault_set;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sp <= '0;
    end else if (w_push) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (w_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stack[IDX_W'(r_sp)] <= w_ret_addr;
  end
`endif

  // A wrapped counter must never see a fetch, even in the first FETCH cycle.
  assign imem_req    = r_req & ~pc_max;
  assign pc_inc      = r_pc_inc;
  assign pc_load     = r_pc_load;
  assign pc_load_val = r_pc_load_val;
  assign ir          = r_ir;
  assign ex_start    = r_ex_start;
  assign busy        = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
  assign halted      = (r_state == S_HALT);
  assign fault       = r_fault;

endmodule
